// File: rtl/mmc1_serial_mapper_p.sv
// mmc1_serial_mapper_p: MMC1 serial-load mapper; optional MMC1_WRAM_DIS_EN (prg MSB drives wram_ce_n); ports: clk/rst, cpu_wr/cpu_a/cpu_d0/cpu_d7 load, ppu_a in, prg_a/chr_a/ciram_a10/load_done/wram_ce_n out
module mmc1_serial_mapper_p #(
  parameter int SHIFT_W    = 5,
  parameter int PRG_BANK_W = 4,
  parameter int CHR_BANK_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_wr,
  input  logic [1:0]            cpu_a,
  input  logic                  cpu_d0,
  input  logic                  cpu_d7,
  input  logic [2:0]            ppu_a,
  output logic [PRG_BANK_W-1:0] prg_a,
  output logic [CHR_BANK_W-1:0] chr_a,
  output logic                  ciram_a10,
  output logic                  load_done,
  output logic                  wram_ce_n
);
  localparam int CW = $clog2(SHIFT_W);
  logic [SHIFT_W-2:0] shift;
  logic [CW-1:0] cnt;
  logic wr_q;
  logic [4:0] ctrl;
  logic [SHIFT_W-1:0] chr0, chr1, prg, value;
  logic [PRG_BANK_W-1:0] pb, prg_mux;
  logic acc, last, unused_bits;
  assign acc = cpu_wr & ~wr_q;
  assign last = cnt == CW'(SHIFT_W - 1);
  assign value = {cpu_d0, shift};
  assign pb = prg[PRG_BANK_W-1:0];
  assign unused_bits = ^{chr0, chr1, prg};
  always_ff @(posedge clk) begin
    if (rst) begin
      shift <= '0;
      cnt <= '0;
      wr_q <= 1'b0;
      ctrl <= 5'b01100;
      chr0 <= '0;
      chr1 <= '0;
      prg <= '0;
      load_done <= 1'b0;
    end else begin
      wr_q <= cpu_wr;
      load_done <= acc & ~cpu_d7 & last;
      if (acc) begin
        if (cpu_d7) begin
          shift <= '0;
          cnt <= '0;
          ctrl[3:2] <= 2'b11;
        end else if (!last) begin
          shift <= {cpu_d0, shift[SHIFT_W-2:1]};
          cnt <= cnt + 1'b1;
        end else begin
          shift <= '0;
          cnt <= '0;
          case (cpu_a)
            2'd0: ctrl <= value[4:0];
            2'd1: chr0 <= value;
            2'd2: chr1 <= value;
            default: prg <= value;
          endcase
        end
      end
    end
  end
  always_comb begin
    ciram_a10 = ctrl[1] ? (ctrl[0] ? ppu_a[1] : ppu_a[0]) : ctrl[0];
    chr_a = ctrl[4] ? (ppu_a[2] ? chr1[CHR_BANK_W-1:0] : chr0[CHR_BANK_W-1:0])
                    : {chr0[CHR_BANK_W-1:1], ppu_a[2]};
    prg_mux = !ctrl[3] ? {pb[PRG_BANK_W-1:1], cpu_a[1]}
            : !ctrl[2] ? (cpu_a[1] ? pb : '0)
            : (cpu_a[1] ? '1 : pb);
`ifdef MMC1_WRAM_DIS_EN
    // the WRAM disable bit never reaches the PRG address lines
    prg_a = (PRG_BANK_W == SHIFT_W) ? {1'b0, prg_mux[PRG_BANK_W-2:0]} : prg_mux;
    wram_ce_n = prg[SHIFT_W-1];
`else
    prg_a = prg_mux;
    wram_ce_n = 1'b0;
`endif
  end
endmodule

// File: tb/tb_mmc1_serial_mapper_p.sv
// tb_mmc1_serial_mapper_p: randomized and directed bench with a behavioural MMC1 model
module tb_mmc1_serial_mapper_p;
  logic clk = 1'b0, rst = 1'b1, cpu_wr = 1'b0, cpu_d0 = 1'b0, cpu_d7 = 1'b0;
  logic [1:0] cpu_a = 2'd0;
  logic [2:0] ppu_a = 3'd0;
  logic [3:0] prg_a;
  logic [4:0] chr_a;
  logic ciram_a10, load_done, wram_ce_n;
  int n_chk = 0, n_fail = 0;
  bit bits_q[$];
  int m_wrq, m_ctrl, m_chr0, m_chr1, m_prg, m_ld;

  mmc1_serial_mapper_p dut (
    .clk(clk), .rst(rst), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_d0(cpu_d0),
    .cpu_d7(cpu_d7), .ppu_a(ppu_a), .prg_a(prg_a), .chr_a(chr_a),
    .ciram_a10(ciram_a10), .load_done(load_done), .wram_ce_n(wram_ce_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    bits_q.delete();
    m_wrq = 0; m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0; m_ld = 0;
  endfunction

  function automatic int exp_prg(int a1);
    int pb = m_prg % 16;
    int mode = (m_ctrl / 4) % 4;
    if (mode < 2) return (pb / 2) * 2 + a1;
    if (mode == 2) return a1 ? pb : 0;
    return a1 ? 15 : pb;
  endfunction

  function automatic int exp_chr(int p);
    int a12 = p / 4;
    if (m_ctrl / 16 == 0) return (m_chr0 / 2) * 2 + a12;
    return a12 ? m_chr1 : m_chr0;
  endfunction

  function automatic int exp_mir(int p);
    case (m_ctrl % 4)
      0: return 0;
      1: return 1;
      2: return p % 2;
      default: return (p / 2) % 2;
    endcase
  endfunction

  function automatic int exp_wram();
`ifdef MMC1_WRAM_DIS_EN
    return (m_prg / 16) % 2;
`else
    return 0;
`endif
  endfunction

  function automatic void m_edge(int w, int a, int d0, int d7, int r);
    int val;
    if (r) begin
      m_reset();
      return;
    end
    m_ld = 0;
    if (w && !m_wrq) begin
      if (d7) begin
        bits_q.delete();
        m_ctrl = m_ctrl | 12;
      end else begin
        bits_q.push_back(d0[0]);
        if (bits_q.size() == 5) begin
          val = 0;
          for (int i = 0; i < 5; i++) val += int'(bits_q[i]) << i;
          bits_q.delete();
          case (a)
            0: m_ctrl = val;
            1: m_chr0 = val;
            2: m_chr1 = val;
            default: m_prg = val;
          endcase
          m_ld = 1;
        end
      end
    end
    m_wrq = w;
  endfunction

  task automatic step(input int w, input int a, input int d0, input int d7, input int r = 0);
    @(negedge clk);
    cpu_wr = w[0]; cpu_a = a[1:0]; cpu_d0 = d0[0]; cpu_d7 = d7[0]; rst = r[0];
    ppu_a = 3'($urandom_range(0, 7));
    #1;
    chk("prg_a", int'(prg_a), exp_prg(a / 2));
    chk("chr_a", int'(chr_a), exp_chr(int'(ppu_a)));
    chk("ciram_a10", int'(ciram_a10), exp_mir(int'(ppu_a)));
    chk("load_done", int'(load_done), m_ld);
    chk("wram_ce_n", int'(wram_ce_n), exp_wram());
    @(posedge clk);
    m_edge(w, a, d0, d7, r);
  endtask

  task automatic wr_bit(input int a, input int d0, input int d7 = 0);
    step(1, a, d0, d7);
    step(0, a, 0, 0);
  endtask

  task automatic load(input int a, input int val);
    for (int i = 0; i < 5; i++) wr_bit(a, (val >> i) & 1);
  endtask

  task automatic peek(input int a, input int p);
    cpu_wr = 1'b0; cpu_a = a[1:0]; ppu_a = p[2:0];
    #2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    m_reset();
    peek(2, 0);
    chk("rst_prg_hi", int'(prg_a), 15);
    peek(0, 0);
    chk("rst_prg_lo", int'(prg_a), 0);
    chk("rst_ciram", int'(ciram_a10), 0);
    chk("rst_wram", int'(wram_ce_n), 0);
    chk("rst_ld", int'(load_done), 0);
    load(3, 5'b00101);
    peek(0, 0);
    chk("prg5", int'(prg_a), 5);
    load(0, 5'b10010);
    load(1, 3);
    load(2, 9);
    peek(0, 0);
    chk("chr4k_lo", int'(chr_a), 3);
    peek(0, 4);
    chk("chr4k_hi", int'(chr_a), 9);
    peek(0, 1);
    chk("vert_a10", int'(ciram_a10), 1);
    peek(0, 2);
    chk("vert_a11", int'(ciram_a10), 0);
    for (int i = 0; i < 3; i++) wr_bit(1, 1);
    wr_bit(1, 0, 1);
    load(1, 7);
    peek(2, 0);
    chk("d7_chr0", int'(chr_a), 7);
    chk("d7_mode3", int'(prg_a), 15);
    step(1, 3, 1, 0);
    step(1, 3, 0, 0);
    step(0, 3, 0, 0);
    wr_bit(3, 0); wr_bit(3, 1); wr_bit(3, 1);
    step(1, 3, 0, 0);
    step(1, 3, 1, 0);
    step(0, 3, 0, 0);
    peek(0, 0);
    chk("rmw_prg", int'(prg_a), 13);
    wr_bit(3, 1); wr_bit(3, 1);
    step(0, 0, 0, 0, 1);
    load(3, 5'b11110);
    peek(0, 0);
    chk("rst_mid_prg", int'(prg_a), 14);
`ifdef MMC1_WRAM_DIS_EN
    chk("wram_dis", int'(wram_ce_n), 1);
`else
    chk("wram_tied", int'(wram_ce_n), 0);
`endif
    for (int i = 0; i < 600; i++)
      step(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 15) == 0), int'($urandom_range(0, 99) == 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
